alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL take parameter REG_COUNT, default 16, the number of architectural registers; register indices are 4 bits wide.
REQ-002 SHALL take parameter WIDTH, default `WORD_SIZE from defines.svh, the data word width.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port IssueValid, input, 1 bit: the instruction on the Issue* inputs is valid.
REQ-006 SHALL have port IssueReady, output, 1 bit: the unit accepts an instruction this cycle.
REQ-007 SHALL have ports IssueOp (input, 4 bits: ALU control code), IssueRs1 and IssueRs2 (inputs, 4 bits each: source register indices), and IssueRd (input, 4 bits: destination register index).
REQ-008 SHALL have ports IssueUseImm (input, 1 bit: use the immediate as operand 2) and IssueImm (input, WIDTH bits: immediate operand).
REQ-009 SHALL have ports AluIn1 and AluIn2 (outputs, WIDTH bits each) and AluControl (output, 4 bits), all driven to an external combinational ALU.
REQ-010 SHALL have port AluOut, input, WIDTH bits: the ALU result.
REQ-011 SHALL have ports WbValid (output, 1 bit), WbRd (output, 4 bits), WbData (output, WIDTH bits), and WbReady (input, 1 bit), forming the writeback handshake.
REQ-012 SHALL have ports DbgAddr (input, 4 bits) and DbgData (output, WIDTH bits): an asynchronous register-file read port.

Function
REQ-013 SHALL contain REG_COUNT registers of WIDTH bits; register 0 always reads 0 and ignores writes.
REQ-014 SHALL implement a four-state FSM:
- IDLE -> READ when IssueValid && IssueReady.
- READ -> EXEC unconditionally.
- EXEC -> WB unconditionally.
- WB -> IDLE when WbReady.
REQ-015 SHALL assert IssueReady only in IDLE; IssueValid is ignored in every other state.
REQ-016 SHALL capture IssueOp, IssueRs1, IssueRs2, IssueRd, IssueUseImm and IssueImm on the accept edge.
REQ-017 SHALL, in READ, latch operand1 = reg[rs1] and operand2 = IssueUseImm ? IssueImm : reg[rs2].
REQ-018 SHALL drive AluIn1, AluIn2 and AluControl from the latched operands and op only in EXEC, and SHALL drive them to 0 in all other states.
REQ-019 SHALL register AluOut into the result register on the edge leaving EXEC.
REQ-020 SHALL, in WB, assert WbValid with WbRd = captured rd and WbData = result, holding all three stable until WbReady is sampled high.
REQ-021 SHALL write the result into reg[rd] on the edge where WB && WbReady, and SHALL discard the write when rd == 0.
REQ-022 SHALL have fixed latency: accept at edge N gives WbValid high in cycle N+3; minimum issue interval is 4 cycles.
REQ-023 SHALL make the writeback visible to the READ of the next instruction (no hazard), because a new instruction cannot be accepted before WB completes.
REQ-024 SHALL make DbgData = reg[DbgAddr] combinationally; an out-of-range DbgAddr returns 0.
REQ-025 SHALL treat data arithmetic as WIDTH bits modulo 2^WIDTH, as produced by the ALU; the unit performs no arithmetic itself.

Reset
REQ-026 SHALL, on Reset high at a rising edge, go to IDLE from any state and abort any in-flight instruction without writing back.
REQ-027 SHALL, on reset, clear every register, the operand latches and the result register to 0.
REQ-028 SHALL hold these output values during and immediately after reset:
- WbValid = 0, WbRd = 0, WbData = 0.
- AluIn1 = 0, AluIn2 = 0, AluControl = 0.
- IssueReady = 1 in the first cycle after Reset deasserts.

Verification
REQ-029 Bench SHALL cover: reset -> IssueReady = 1, WbValid = 0, DbgData = 0 for DbgAddr 0..15.
REQ-030 Bench SHALL cover: issue op = 0000, rs1 = 0, UseImm = 1, Imm = 5, rd = 1 at cycle 0 -> EXEC in cycle 2 with AluIn1 = 0 and AluIn2 = 5; WbValid in cycle 3 with WbRd = 1 and WbData = 5; with WbReady = 1, DbgAddr = 1 reads 5.
REQ-031 Bench SHALL cover: r2 = r1 + r1, then r3 = r2 + imm all-ones -> r2 = 10 and r3 = 9 (wrap-around).
REQ-032 Bench SHALL cover: op 0000, rs1 = 1, UseImm = 1, Imm = 7, rd = 0 -> WbData = 12 and DbgAddr = 0 reads 0.
REQ-033 Bench SHALL cover: WbReady held low for 5 cycles while IssueValid = 1 -> WbValid, WbRd and WbData stay constant, IssueReady = 0, and no second accept; accept resumes the cycle after the WB handshake.
REQ-034 Bench SHALL cover: Reset pulsed during EXEC of an instruction targeting r4 -> WbValid never rises, IDLE the next cycle, and r4 reads 0.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Single-issue ALU sequencer: register file, operand read, external ALU drive
// and writeback handshake, one instruction in flight at a time.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_issue_unit #(
  parameter int REG_COUNT = 16,
  parameter int WIDTH     = `WORD_SIZE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IssueValid,
  output logic             IssueReady,
  input  logic [3:0]       IssueOp,
  input  logic [3:0]       IssueRs1,
  input  logic [3:0]       IssueRs2,
  input  logic [3:0]       IssueRd,
  input  logic             IssueUseImm,
  input  logic [WIDTH-1:0] IssueImm,
  output logic [WIDTH-1:0] AluIn1,
  output logic [WIDTH-1:0] AluIn2,
  output logic [3:0]       AluControl,
  input  logic [WIDTH-1:0] AluOut,
  output logic             WbValid,
  output logic [3:0]       WbRd,
  output logic [WIDTH-1:0] WbData,
  input  logic             WbReady,
  input  logic [3:0]       DbgAddr,
  output logic [WIDTH-1:0] DbgData
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] regs [REG_COUNT];

  logic [3:0]       op_p0, rs1_p0, rs2_p0, rd_p0;
  logic             use_imm_p0;
  logic [WIDTH-1:0] imm_p0;
  logic [WIDTH-1:0] opnd1_p1, opnd2_p1;
  logic [WIDTH-1:0] result_p2;

  logic             accept, wb_fire;
  logic [WIDTH-1:0] rs1_val, rs2_val;

  function automatic logic in_range(input logic [3:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  // Register 0 is never written, so it reads 0 without a special case.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    DbgData = '0;
    if (in_range(rs1_p0))  rs1_val = regs[rs1_p0];
    if (in_range(rs2_p0))  rs2_val = regs[rs2_p0];
    if (in_range(DbgAddr)) DbgData = regs[DbgAddr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    IssueReady = 1'b0;
    AluIn1     = '0;
    AluIn2     = '0;
    AluControl = '0;
    WbValid    = 1'b0;
    WbRd       = '0;
    WbData     = '0;
    case (state)
      IDLE: begin
        IssueReady = 1'b1;
        if (IssueValid) state_next = READ;
      end
      READ: state_next = EXEC;
      EXEC: begin
        AluIn1     = opnd1_p1;
        AluIn2     = opnd2_p1;
        AluControl = op_p0;
        state_next = WB;
      end
      WB: begin
        WbValid = 1'b1;
        WbRd    = rd_p0;
        WbData  = result_p2;
        if (WbReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = IssueReady && IssueValid;
  assign wb_fire = (state == WB) && WbReady;

  // p0: instruction fields captured on the accept edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_p0      <= '0;
      rs1_p0     <= '0;
      rs2_p0     <= '0;
      rd_p0      <= '0;
      use_imm_p0 <= 1'b0;
      imm_p0     <= '0;
    end else if (accept) begin
      op_p0      <= IssueOp;
      rs1_p0     <= IssueRs1;
      rs2_p0     <= IssueRs2;
      rd_p0      <= IssueRd;
      use_imm_p0 <= IssueUseImm;
      imm_p0     <= IssueImm;
    end
  end

  // p1: operands latched in READ
  always_ff @(posedge Clk) begin
    if (Reset) begin
      opnd1_p1 <= '0;
      opnd2_p1 <= '0;
    end else if (state == READ) begin
      opnd1_p1 <= rs1_val;
      opnd2_p1 <= use_imm_p0 ? imm_p0 : rs2_val;
    end
  end

  // p2: ALU result captured on the edge leaving EXEC
  always_ff @(posedge Clk) begin
    if (Reset)              result_p2 <= '0;
    else if (state == EXEC) result_p2 <= AluOut;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_fire && (rd_p0 != 4'd0) && in_range(rd_p0)) begin
      regs[rd_p0] <= result_p2;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small combinational ALU model
// standing in for the external ALU.
module tb_alu_issue_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         IssueValid = 1'b0;
  logic         IssueReady;
  logic [3:0]   IssueOp = '0, IssueRs1 = '0, IssueRs2 = '0, IssueRd = '0;
  logic         IssueUseImm = 1'b0;
  logic [W-1:0] IssueImm = '0;
  logic [W-1:0] AluIn1, AluIn2, AluOut;
  logic [3:0]   AluControl;
  logic         WbValid;
  logic [3:0]   WbRd;
  logic [W-1:0] WbData;
  logic         WbReady = 1'b1;
  logic [3:0]   DbgAddr = '0;
  logic [W-1:0] DbgData;

  int total = 0;
  int bad   = 0;

  alu_issue_unit #(.REG_COUNT(16), .WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .IssueReady(IssueReady),
    .IssueOp(IssueOp), .IssueRs1(IssueRs1), .IssueRs2(IssueRs2), .IssueRd(IssueRd),
    .IssueUseImm(IssueUseImm), .IssueImm(IssueImm),
    .AluIn1(AluIn1), .AluIn2(AluIn2), .AluControl(AluControl), .AluOut(AluOut),
    .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData), .WbReady(WbReady),
    .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  always #5 Clk = ~Clk;

  // External ALU: 0 add, 1 sub, 2 and, 3 or.
  always_comb begin
    case (AluControl)
      4'd0:    AluOut = AluIn1 + AluIn2;
      4'd1:    AluOut = AluIn1 - AluIn2;
      4'd2:    AluOut = AluIn1 & AluIn2;
      4'd3:    AluOut = AluIn1 | AluIn2;
      default: AluOut = '0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic use_imm, input logic [W-1:0] imm);
    IssueValid  = 1'b1;
    IssueOp     = op;
    IssueRs1    = rs1;
    IssueRs2    = rs2;
    IssueRd     = rd;
    IssueUseImm = use_imm;
    IssueImm    = imm;
  endtask

  // Issues one instruction from IDLE, returns what WB presented, ends in IDLE.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic use_imm, input logic [W-1:0] imm,
                           output logic ov, output logic [3:0] ord, output logic [W-1:0] odata);
    WbReady = 1'b1;
    drive(op, rs1, rs2, rd, use_imm, imm);
    tick();
    IssueValid = 1'b0;
    tick();
    tick();
    ov = WbValid;
    ord = WbRd;
    odata = WbData;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    total++; if (WbValid !== 1'b0) begin bad++; $display("FAIL rst_wbvalid_during got=%0b want=0", WbValid); end
    total++; if (AluIn1 !== '0 || AluIn2 !== '0 || AluControl !== '0) begin bad++; $display("FAIL rst_alu_during got=%0h/%0h/%0h want=0", AluIn1, AluIn2, AluControl); end
    Reset = 1'b0;
    total++; if (IssueReady !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", IssueReady); end
    total++; if (WbValid !== 1'b0 || WbRd !== 4'd0 || WbData !== '0) begin bad++; $display("FAIL rst_wb got=%0b/%0d/%0h want=0/0/0", WbValid, WbRd, WbData); end
    for (int i = 0; i < 16; i++) begin
      DbgAddr = 4'(i);
      #1;
      total++; if (DbgData !== '0) begin bad++; $display("FAIL rst_dbg r%0d got=%0h want=0", i, DbgData); end
    end
  endtask

  task automatic test_imm_load();
    tick();
    WbReady = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd5);
    total++; if (IssueReady !== 1'b1) begin bad++; $display("FAIL imm_ready0 got=%0b want=1", IssueReady); end
    tick();
    IssueValid = 1'b0;
    total++; if (IssueReady !== 1'b0 || AluIn2 !== '0 || WbValid !== 1'b0) begin bad++; $display("FAIL imm_read got=%0b/%0h/%0b want=0/0/0", IssueReady, AluIn2, WbValid); end
    tick();
    total++; if (AluIn1 !== 32'd0 || AluIn2 !== 32'd5 || AluControl !== 4'd0) begin bad++; $display("FAIL imm_exec got=%0h/%0h/%0h want=0/5/0", AluIn1, AluIn2, AluControl); end
    total++; if (WbValid !== 1'b0) begin bad++; $display("FAIL imm_exec_wbvalid got=%0b want=0", WbValid); end
    tick();
    total++; if (WbValid !== 1'b1 || WbRd !== 4'd1 || WbData !== 32'd5) begin bad++; $display("FAIL imm_wb got=%0b/%0d/%0d want=1/1/5", WbValid, WbRd, WbData); end
    total++; if (AluIn2 !== '0) begin bad++; $display("FAIL imm_wb_aluin2 got=%0h want=0", AluIn2); end
    tick();
    DbgAddr = 4'd1;
    #1;
    total++; if (IssueReady !== 1'b1 || WbValid !== 1'b0) begin bad++; $display("FAIL imm_idle got=%0b/%0b want=1/0", IssueReady, WbValid); end
    total++; if (DbgData !== 32'd5) begin bad++; $display("FAIL imm_r1 got=%0d want=5", DbgData); end
  endtask

  task automatic test_chain();
    logic ov; logic [3:0] ord; logic [W-1:0] od;
    run_instr(4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 32'd0, ov, ord, od);
    total++; if (ov !== 1'b1 || ord !== 4'd2 || od !== 32'd10) begin bad++; $display("FAIL chain_r2_wb got=%0b/%0d/%0d want=1/2/10", ov, ord, od); end
    run_instr(4'd0, 4'd2, 4'd0, 4'd3, 1'b1, 32'hFFFF_FFFF, ov, ord, od);
    total++; if (ov !== 1'b1 || ord !== 4'd3 || od !== 32'd9) begin bad++; $display("FAIL chain_r3_wb got=%0b/%0d/%0d want=1/3/9", ov, ord, od); end
    DbgAddr = 4'd2; #1;
    total++; if (DbgData !== 32'd10) begin bad++; $display("FAIL chain_r2 got=%0d want=10", DbgData); end
    DbgAddr = 4'd3; #1;
    total++; if (DbgData !== 32'd9) begin bad++; $display("FAIL chain_r3 got=%0d want=9", DbgData); end
  endtask

  task automatic test_rd_zero();
    logic ov; logic [3:0] ord; logic [W-1:0] od;
    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd7, ov, ord, od);
    total++; if (ov !== 1'b1 || ord !== 4'd0 || od !== 32'd12) begin bad++; $display("FAIL rd0_wb got=%0b/%0d/%0d want=1/0/12", ov, ord, od); end
    DbgAddr = 4'd0; #1;
    total++; if (DbgData !== 32'd0) begin bad++; $display("FAIL rd0_r0 got=%0d want=0", DbgData); end
  endtask

  task automatic test_ops();
    logic ov; logic [3:0] ord; logic [W-1:0] od;
    run_instr(4'd1, 4'd3, 4'd1, 4'd5, 1'b0, 32'd0, ov, ord, od);
    total++; if (ord !== 4'd5 || od !== 32'd4) begin bad++; $display("FAIL sub_wb got=%0d/%0d want=5/4", ord, od); end
    run_instr(4'd2, 4'd2, 4'd0, 4'd6, 1'b1, 32'd6, ov, ord, od);
    total++; if (ord !== 4'd6 || od !== 32'd2) begin bad++; $display("FAIL and_wb got=%0d/%0d want=6/2", ord, od); end
    DbgAddr = 4'd5; #1;
    total++; if (DbgData !== 32'd4) begin bad++; $display("FAIL sub_r5 got=%0d want=4", DbgData); end
    DbgAddr = 4'd6; #1;
    total++; if (DbgData !== 32'd2) begin bad++; $display("FAIL and_r6 got=%0d want=2", DbgData); end
  endtask

  task automatic test_backpressure();
    WbReady = 1'b0;
    drive(4'd0, 4'd1, 4'd0, 4'd7, 1'b1, 32'd3);
    tick();
    drive(4'd0, 4'd1, 4'd0, 4'd8, 1'b1, 32'd100);
    total++; if (IssueReady !== 1'b0) begin bad++; $display("FAIL bp_read_ready got=%0b want=0", IssueReady); end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (WbValid !== 1'b1 || WbRd !== 4'd7 || WbData !== 32'd8 || IssueReady !== 1'b0) begin
        bad++; $display("FAIL bp_hold c%0d got=%0b/%0d/%0d/%0b want=1/7/8/0", i, WbValid, WbRd, WbData, IssueReady);
      end
      tick();
    end
    WbReady = 1'b1;
    tick();
    DbgAddr = 4'd7; #1;
    total++; if (IssueReady !== 1'b1 || WbValid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b/%0b want=1/0", IssueReady, WbValid); end
    total++; if (DbgData !== 32'd8) begin bad++; $display("FAIL bp_r7 got=%0d want=8", DbgData); end
    tick();
    IssueValid = 1'b0;
    total++; if (IssueReady !== 1'b0) begin bad++; $display("FAIL bp_accept got=%0b want=0", IssueReady); end
    tick();
    total++; if (AluIn1 !== 32'd5 || AluIn2 !== 32'd100) begin bad++; $display("FAIL bp_exec2 got=%0d/%0d want=5/100", AluIn1, AluIn2); end
    tick();
    total++; if (WbValid !== 1'b1 || WbRd !== 4'd8 || WbData !== 32'd105) begin bad++; $display("FAIL bp_wb2 got=%0b/%0d/%0d want=1/8/105", WbValid, WbRd, WbData); end
    tick();
    DbgAddr = 4'd8; #1;
    total++; if (IssueReady !== 1'b1 || WbValid !== 1'b0) begin bad++; $display("FAIL bp_idle2 got=%0b/%0b want=1/0", IssueReady, WbValid); end
    total++; if (DbgData !== 32'd105) begin bad++; $display("FAIL bp_r8 got=%0d want=105", DbgData); end
  endtask

  task automatic test_reset_abort();
    tick();
    WbReady = 1'b1;
    drive(4'd0, 4'd1, 4'd0, 4'd4, 1'b1, 32'd20);
    tick();
    IssueValid = 1'b0;
    tick();
    total++; if (AluIn1 !== 32'd5 || AluIn2 !== 32'd20) begin bad++; $display("FAIL abort_exec got=%0d/%0d want=5/20", AluIn1, AluIn2); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++; if (IssueReady !== 1'b1 || WbValid !== 1'b0 || AluIn2 !== '0) begin bad++; $display("FAIL abort_idle got=%0b/%0b/%0h want=1/0/0", IssueReady, WbValid, AluIn2); end
    for (int i = 0; i < 4; i++) begin
      total++; if (WbValid !== 1'b0) begin bad++; $display("FAIL abort_wbvalid c%0d got=%0b want=0", i, WbValid); end
      tick();
    end
    DbgAddr = 4'd4; #1;
    total++; if (DbgData !== 32'd0) begin bad++; $display("FAIL abort_r4 got=%0d want=0", DbgData); end
    DbgAddr = 4'd8; #1;
    total++; if (DbgData !== 32'd0) begin bad++; $display("FAIL abort_r8_cleared got=%0d want=0", DbgData); end
  endtask

  initial begin
    test_reset();
    test_imm_load();
    test_chain();
    test_rd_zero();
    test_ops();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
